// File: rtl/led_fader_pkg.sv
// Shared types and helpers for the LED fader.
// Build option: define LED_FADER_GAMMA_EN to render brightness through a
// square-law gamma curve instead of a linear duty cycle.
package led_fader_pkg;

    // Default level/PWM width. The top and the channels may be built at a
    // different width through their PWM_BITS parameter.
    localparam int unsigned DEFAULT_PWM_BITS = 8;

    // Width used for the saturating arithmetic. It is one bit wider than the
    // largest supported level, so a sum never wraps. This covers PWM_BITS up
    // to 16.
    localparam int unsigned SAT_W = 17;

    typedef logic [DEFAULT_PWM_BITS-1:0] level_t;
    typedef logic [SAT_W-1:0]            sat_t;

    localparam level_t LEVEL_MAX = '1;

    // Moves a level one fade step toward full-on (up=1) or toward off (up=0).
    // The result clamps at max_level on the way up and at 0 on the way down.
    function automatic sat_t sat_step(input sat_t level, input logic up,
                                      input sat_t step, input sat_t max_level);
        sat_t sum;
        sum = level + step;
        if (up) begin
            sat_step = (sum > max_level) ? max_level : sum;
        end else begin
            sat_step = (level > step) ? (level - step) : '0;
        end
    endfunction

endpackage

// File: rtl/led_fader_channel.sv
// One LED channel: a brightness level register with a saturating fade, an
// optional gamma mapping, and the PWM compare that drives the pin.
// Build option: LED_FADER_GAMMA_EN selects duty = level^2 >> PWM_BITS.
module led_fader_channel
    import led_fader_pkg::*;
#(
    parameter int unsigned PWM_BITS  = 8,
    parameter int unsigned FADE_STEP = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                tick_i,
    input  logic                target_i,
    input  logic [PWM_BITS-1:0] pwm_cnt_i,
    output logic                led_o
);

    localparam logic [PWM_BITS-1:0] LVL_MAX = '1;

    logic [PWM_BITS-1:0] level_q, level_d;
    logic [PWM_BITS-1:0] duty;
    logic                led_q, led_d;

    // Next level: hold between ticks, step toward the target on a tick.
    always_comb begin
        // NOTE: every combinational output gets a default first so that no
        // path through the block leaves it unassigned and infers a latch.
        level_d = level_q;
        if (tick_i) begin
            level_d = PWM_BITS'(sat_step(sat_t'(level_q), target_i,
                                         sat_t'(FADE_STEP), sat_t'(LVL_MAX)));
        end
    end

`ifdef LED_FADER_GAMMA_EN
    logic [2*PWM_BITS-1:0] level_sq;

    // Square-law gamma: keep the upper half of level*level.
    always_comb begin
        level_sq = {{PWM_BITS{1'b0}}, level_q} * {{PWM_BITS{1'b0}}, level_q};
        duty     = level_sq[2*PWM_BITS-1:PWM_BITS];
    end
`else
    assign duty = level_q;
`endif

    // PWM compare. A full-scale level is forced solid on, whatever the duty.
    always_comb begin
        led_d = (duty > pwm_cnt_i) || (level_q == LVL_MAX);
    end

    // Level and output registers.
    always_ff @(posedge clk) begin
        // NOTE: sequential state is written with non-blocking assignments so
        // every register samples the values from before this edge.
        if (rst) begin
            level_q <= '0;
            led_q   <= 1'b0;
        end else begin
            level_q <= level_d;
            led_q   <= led_d;
        end
    end

    assign led_o = led_q;

endmodule

// File: rtl/led_fader.sv
// LED fader top level. It holds the pattern register, the fade prescaler,
// the shared PWM counter and the fade_tick debug pulse, and it instantiates
// one led_fader_channel per LED.
// Build option: LED_FADER_GAMMA_EN enables gamma mapping in every channel.
module led_fader
    import led_fader_pkg::*;
#(
    parameter int unsigned N_LEDS        = 5,
    parameter int unsigned PWM_BITS      = DEFAULT_PWM_BITS,
    parameter int unsigned FADE_DIV_LOG2 = 16,
    parameter int unsigned FADE_STEP     = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N_LEDS-1:0] pattern,
    output logic [N_LEDS-1:0] led,
    output logic              fade_tick
);

    logic [N_LEDS-1:0]        pattern_q;
    logic [FADE_DIV_LOG2-1:0] presc_q, presc_d;
    logic [PWM_BITS-1:0]      pwm_cnt_q, pwm_cnt_d;
    logic                     fade_tick_q;
    logic                     tick;

    // Free-running counters and the internal tick (prescaler all-ones).
    always_comb begin
        presc_d   = presc_q + 1'b1;
        pwm_cnt_d = pwm_cnt_q + 1'b1;
        tick      = (presc_q == '1);
    end

    // Pattern, prescaler, PWM counter and the registered tick pulse.
    always_ff @(posedge clk) begin
        // NOTE: reset is synchronous; only control and counter registers sit
        // behind it here, and the same reset clears the level registers inside
        // the channels.
        if (rst) begin
            pattern_q   <= '0;
            presc_q     <= '0;
            pwm_cnt_q   <= '0;
            fade_tick_q <= 1'b0;
        end else begin
            pattern_q   <= pattern;
            presc_q     <= presc_d;
            pwm_cnt_q   <= pwm_cnt_d;
            fade_tick_q <= tick;
        end
    end

    for (genvar i = 0; i < N_LEDS; i++) begin : gen_chan
        led_fader_channel #(
            .PWM_BITS (PWM_BITS),
            .FADE_STEP(FADE_STEP)
        ) u_chan (
            .clk      (clk),
            .rst      (rst),
            .tick_i   (tick),
            .target_i (pattern_q[i]),
            .pwm_cnt_i(pwm_cnt_q),
            .led_o    (led[i])
        );
    end

    assign fade_tick = fade_tick_q;

endmodule

// File: tb/tb_led_fader.sv
// Self-checking bench for led_fader at PWM_BITS=4, FADE_DIV_LOG2=2,
// FADE_STEP=4 and N_LEDS=5. The reference model counts clocks since reset:
// the PWM phase is that count mod 16, and a fade tick happens on every edge
// that completes a group of 4 clocks.
module tb_led_fader;

    localparam int N    = 5;
    localparam int PB   = 4;
    localparam int STEP = 4;
    localparam int LMAX = 15;
    localparam int PER  = 16;
    localparam int TPER = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic [N-1:0] pattern;
    logic [N-1:0] led;
    logic         fade_tick;

    int checks = 0;
    int errors = 0;

    // Reference model state.
    int           m_level[N];
    logic [N-1:0] m_pat_q;
    logic [N-1:0] m_led;
    logic         m_tick;
    int           m_n;

    led_fader #(
        .N_LEDS       (N),
        .PWM_BITS     (PB),
        .FADE_DIV_LOG2(2),
        .FADE_STEP    (STEP)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .pattern  (pattern),
        .led      (led),
        .fade_tick(fade_tick)
    );

    always #5 clk = ~clk;

    function automatic int duty_of(input int lvl);
`ifdef LED_FADER_GAMMA_EN
        return (lvl * lvl) >> PB;
`else
        return lvl;
`endif
    endfunction

    task automatic model_reset();
        for (int i = 0; i < N; i++) m_level[i] = 0;
        m_pat_q = '0;
        m_led   = '0;
        m_tick  = 1'b0;
        m_n     = 0;
    endtask

    // Advances one clock, updates the model from the inputs seen at that
    // edge, and returns at the following falling edge.
    task automatic cycle();
        @(posedge clk);
        if (rst) begin
            model_reset();
        end else begin
            for (int i = 0; i < N; i++)
                m_led[i] = (duty_of(m_level[i]) > (m_n % PER)) || (m_level[i] == LMAX);
            m_tick = ((m_n % TPER) == TPER - 1);
            if (m_tick) begin
                for (int i = 0; i < N; i++) begin
                    if (m_pat_q[i]) m_level[i] = (m_level[i] + STEP > LMAX) ? LMAX : m_level[i] + STEP;
                    else            m_level[i] = (m_level[i] < STEP) ? 0 : m_level[i] - STEP;
                end
            end
            m_pat_q = pattern;
            m_n++;
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cycle();
        cycle();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        int first;
        rst     = 1'b1;
        pattern = '1;
        for (int k = 0; k < 3; k++) begin
            cycle();
            checks++;
            if (led !== '0 || fade_tick !== 1'b0) begin
                errors++;
                $display("FAIL reset_outputs: led=%b fade_tick=%b, want led=00000 fade_tick=0", led, fade_tick);
            end
        end
        rst   = 1'b0;
        first = -1;
        for (int k = 1; k <= 8 && first < 0; k++) begin
            cycle();
            if (fade_tick === 1'b1) first = k;
        end
        checks++;
        if (first != 4) begin
            errors++;
            $display("FAIL first_tick: got first fade_tick at cycle %0d, want 4", first);
        end
    endtask

    task automatic test_fade_up();
        int exp_lvl[5] = '{4, 8, 12, 15, 15};
        int t = 0;
        do_reset();
        pattern = 5'b00001;
        for (int cyc = 0; cyc < 40 && t < 5; cyc++) begin
            cycle();
            checks++;
            if (led !== m_led || fade_tick !== m_tick) begin
                errors++;
                $display("FAIL fade_up_cycle: led=%b tick=%b, want led=%b tick=%b", led, fade_tick, m_led, m_tick);
            end
            if (m_tick) begin
                checks++;
                if (dut.gen_chan[0].u_chan.level_q !== 4'(exp_lvl[t])) begin
                    errors++;
                    $display("FAIL fade_up_level: tick %0d level=%0d, want %0d", t, dut.gen_chan[0].u_chan.level_q, exp_lvl[t]);
                end
                t++;
            end
        end
        checks++;
        if (t < 5) begin
            errors++;
            $display("FAIL fade_up_timeout: saw %0d ticks, want 5", t);
        end
        for (int k = 0; k < 16; k++) begin
            cycle();
            checks++;
            if (led !== 5'b00001) begin
                errors++;
                $display("FAIL fade_up_solid: led=%b, want 00001", led);
            end
        end
    endtask

    task automatic test_fade_down();
        int exp_lvl[5] = '{11, 7, 3, 0, 0};
        int t = 0;
        pattern = 5'b00000;
        for (int cyc = 0; cyc < 40 && t < 5; cyc++) begin
            cycle();
            checks++;
            if (led !== m_led || fade_tick !== m_tick) begin
                errors++;
                $display("FAIL fade_down_cycle: led=%b tick=%b, want led=%b tick=%b", led, fade_tick, m_led, m_tick);
            end
            if (m_tick) begin
                checks++;
                if (dut.gen_chan[0].u_chan.level_q !== 4'(exp_lvl[t])) begin
                    errors++;
                    $display("FAIL fade_down_level: tick %0d level=%0d, want %0d", t, dut.gen_chan[0].u_chan.level_q, exp_lvl[t]);
                end
                t++;
            end
        end
        checks++;
        if (t < 5) begin
            errors++;
            $display("FAIL fade_down_timeout: saw %0d ticks, want 5", t);
        end
        for (int k = 0; k < 16; k++) begin
            cycle();
            checks++;
            if (led !== 5'b00000) begin
                errors++;
                $display("FAIL fade_down_solid: led=%b, want 00000", led);
            end
        end
    endtask

    // Bring channel 0 to level 8, then flip the pattern on every tick so it
    // oscillates between 4 and 8. Each 16-cycle window's count of high cycles
    // is checked against the model, along with every cycle.
    task automatic test_duty();
        int t = 0;
        int hi, m_hi;
        do_reset();
        pattern = 5'b00001;
        for (int cyc = 0; cyc < 20 && t < 2; cyc++) begin
            cycle();
            if (m_tick) t++;
        end
        checks++;
        if (dut.gen_chan[0].u_chan.level_q !== 4'd8) begin
            errors++;
            $display("FAIL duty_setup: level=%0d, want 8", dut.gen_chan[0].u_chan.level_q);
        end
        pattern = 5'b00000;
        for (int w = 0; w < 4; w++) begin
            hi   = 0;
            m_hi = 0;
            for (int k = 0; k < PER; k++) begin
                cycle();
                if (m_tick) pattern = ~pattern & 5'b00001;
                hi   += int'(led[0]);
                m_hi += int'(m_led[0]);
                checks++;
                if (led !== m_led) begin
                    errors++;
                    $display("FAIL duty_cycle: led=%b, want %b", led, m_led);
                end
            end
            checks++;
            if (hi != m_hi) begin
                errors++;
                $display("FAIL duty_window: window %0d high=%0d, want %0d", w, hi, m_hi);
            end
        end
    endtask

    task automatic test_mid_reset();
        int t = 0;
        do_reset();
        pattern = 5'b00100;
        for (int cyc = 0; cyc < 20 && t < 2; cyc++) begin
            cycle();
            if (m_tick) t++;
        end
        checks++;
        if (dut.gen_chan[2].u_chan.level_q !== 4'd8) begin
            errors++;
            $display("FAIL mid_reset_setup: level=%0d, want 8", dut.gen_chan[2].u_chan.level_q);
        end
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        checks++;
        if (led !== '0 || fade_tick !== 1'b0 || dut.gen_chan[2].u_chan.level_q !== 4'd0) begin
            errors++;
            $display("FAIL mid_reset_clear: led=%b tick=%b level=%0d, want 00000 0 0", led, fade_tick, dut.gen_chan[2].u_chan.level_q);
        end
        t = 0;
        for (int cyc = 0; cyc < 20 && t < 1; cyc++) begin
            cycle();
            checks++;
            if (led !== m_led || fade_tick !== m_tick) begin
                errors++;
                $display("FAIL mid_reset_resume: led=%b tick=%b, want led=%b tick=%b", led, fade_tick, m_led, m_tick);
            end
            if (m_tick) t++;
        end
        checks++;
        if (dut.gen_chan[2].u_chan.level_q !== 4'd4) begin
            errors++;
            $display("FAIL mid_reset_level: level=%0d, want 4", dut.gen_chan[2].u_chan.level_q);
        end
    endtask

    // Random patterns every cycle with occasional resets. All channels rise
    // and fall independently and are checked every cycle.
    task automatic test_random();
        do_reset();
        for (int k = 0; k < 1200; k++) begin
            pattern = N'($urandom);
            if ($urandom_range(0, 99) < 70) pattern = m_pat_q;
            rst = ($urandom_range(0, 199) == 0);
            cycle();
            checks++;
            if (led !== m_led || fade_tick !== m_tick) begin
                errors++;
                $display("FAIL random_cycle %0d: led=%b tick=%b, want led=%b tick=%b", k, led, fade_tick, m_led, m_tick);
            end
        end
        rst = 1'b0;
    endtask

    initial begin
        rst     = 1'b1;
        pattern = '0;
        model_reset();
        test_reset();
        test_fade_up();
        test_fade_down();
        test_duty();
        test_mid_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
